serv_bus_arbiter: RTL and testbench
===================================

Name: serv_bus_arbiter

Overview:
Shares one 32-bit Wishbone-style memory port between the SERV instruction bus and data bus. It sits between serv_rf_top (ibus/dbus cyc/ack ports) and the single-ported memory or peripheral interconnect. A small FSM grants one requester at a time, holds the grant until ack or abort, and routes ack and read data back to the granted side.

Parameters:
FAIR, 0, 0 = dbus always wins simultaneous requests; 1 = alternate winner on simultaneous requests using a last-grant bit.
TIMEOUT, 255, cycles without ack before the watchdog fires (used only with ARB_TIMEOUT_EN); 8-bit counter, legal range 1..255.

Ports:
clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ibus_adr  in  32  instruction fetch address
i_ibus_cyc  in  1  instruction request, held until ack
o_ibus_rdt  out  32  instruction read data
o_ibus_ack  out  1  instruction ack
i_dbus_adr  in  32  data address
i_dbus_dat  in  32  write data
i_dbus_sel  in  4  byte enables
i_dbus_we  in  1  write enable
i_dbus_cyc  in  1  data request, held until ack
o_dbus_rdt  out  32  data read data
o_dbus_ack  out  1  data ack
o_wb_adr  out  32  shared port address
o_wb_dat  out  32  shared port write data
o_wb_sel  out  4  shared port byte enables
o_wb_we  out  1  shared port write enable
o_wb_cyc  out  1  shared port request
i_wb_rdt  in  32  shared port read data
i_wb_ack  in  1  shared port ack, single-cycle pulse
o_timeout  out  1  watchdog fired, sticky (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset is asynchronous and active-low: i_rst_n low forces state IDLE, last_grant=IBUS, counter=0, o_timeout=0. All outputs are 0 while in IDLE.
- States: IDLE, GNT_I, GNT_D (2-bit register).
- IDLE: i_dbus_cyc only -> GNT_D. i_ibus_cyc only -> GNT_I. Both high: FAIR=0 -> GNT_D; FAIR=1 -> the side opposite last_grant. Neither -> stay IDLE.
- last_grant is updated on every IDLE->GNT_x transition.
- GNT_I: o_wb_adr=i_ibus_adr; o_wb_dat=0; o_wb_sel=4'hF; o_wb_we=0; o_wb_cyc=i_ibus_cyc.
- GNT_D: o_wb_adr/dat/sel/we are driven from the dbus inputs; o_wb_cyc=i_dbus_cyc.
- In IDLE, all o_wb_* outputs are 0.
- Ack routing (combinational): o_ibus_ack = i_wb_ack & (state==GNT_I); o_dbus_ack = i_wb_ack & (state==GNT_D).
- o_ibus_rdt and o_dbus_rdt = i_wb_rdt when the matching ack is high, else 0.
- Ack in GNT_x -> IDLE on the next edge. Re-arbitration always passes through one IDLE cycle; no back-to-back grants.
- Latency: request seen at edge N -> o_wb_cyc high in cycle N+1. The earliest ack is in cycle N+1, seen by the requester in the same cycle.
- Abort: granted requester drops cyc before ack -> o_wb_cyc falls in the same cycle (gated) and state -> IDLE at the next edge. A late i_wb_ack that then arrives in IDLE is dropped and not forwarded.
- i_wb_ack in IDLE is ignored.
- The non-granted requester may raise or drop cyc freely without affecting the current grant.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to GNT_x and increments each cycle in GNT_x without i_wb_ack.
- When the counter reaches TIMEOUT, the arbiter issues a one-cycle ack to the granted side with rdt=32'h0 and returns to IDLE.
- o_timeout sets and stays high until reset. o_wb_cyc drops in that same cycle.
- Not defined: no counter is built, a grant waits forever, and o_timeout is constant 0.

Test Plan:
- ibus only, adr=0x100, memory acks 1 cycle after cyc with rdt=0x00000013 -> o_wb_adr=0x100 with we=0 and sel=F; o_ibus_ack pulses once with o_ibus_rdt=0x13; o_dbus_ack stays 0.
- dbus write, adr=0x2000, dat=0xA5A5A5A5, sel=0x3 -> o_wb_* mirrors these values with we=1; ack goes to dbus only; next cycle is IDLE with o_wb_cyc=0.
- Both cyc asserted from IDLE, FAIR=0 -> dbus is granted first and ibus after one IDLE cycle. FAIR=1 over 4 simultaneous rounds -> grants alternate D, I, D, I.
- Abort: ibus granted, i_ibus_cyc drops in cycle 2, memory acks in cycle 3 -> o_wb_cyc=0 in cycle 2 and no o_ibus_ack or o_dbus_ack in cycle 3.
- Reset mid-grant: i_rst_n low during GNT_D -> o_wb_cyc=0 immediately (asynchronous); after release with no requests, state is IDLE and all outputs are 0.
- ARB_TIMEOUT_EN, TIMEOUT=4, memory never acks -> dbus ack fires 4 cycles after grant with rdt=0, o_timeout=1 and stays 1; a following ibus request still completes normally.

Source files
------------

// File: rtl/serv_bus_arbiter.sv
// Two-requester arbiter sharing one Wishbone-style port between SERV ibus and dbus.
// Optional watchdog built when ARB_TIMEOUT_EN is defined.
module serv_bus_arbiter #(
    parameter int FAIR    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;  // 1 = dbus was granted last
    logic   to_hit;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       to_flag;

    // A real ack in the same cycle wins over the watchdog.
    assign to_hit    = (state != IDLE) && (cnt == 8'(TIMEOUT)) && !i_wb_ack;
    assign o_timeout = to_flag | to_hit;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == IDLE)
                cnt <= '0;
            else if (!i_wb_ack && !to_hit)
                cnt <= cnt + 8'd1;
            if (to_hit)
                to_flag <= 1'b1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (i_dbus_cyc && i_ibus_cyc)
                    state_nxt = (FAIR != 0 && last_grant) ? GNT_I : GNT_D;
                else if (i_dbus_cyc)
                    state_nxt = GNT_D;
                else if (i_ibus_cyc)
                    state_nxt = GNT_I;
                if (state_nxt == GNT_D)
                    last_grant_nxt = 1'b1;
                else if (state_nxt == GNT_I)
                    last_grant_nxt = 1'b0;
            end
            GNT_I: if (i_wb_ack || !i_ibus_cyc || to_hit) state_nxt = IDLE;
            GNT_D: if (i_wb_ack || !i_dbus_cyc || to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_wb_adr   = '0;
        o_wb_dat   = '0;
        o_wb_sel   = '0;
        o_wb_we    = 1'b0;
        o_wb_cyc   = 1'b0;
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        o_ibus_rdt = '0;
        o_dbus_rdt = '0;
        case (state)
            GNT_I: begin
                o_wb_adr   = i_ibus_adr;
                o_wb_sel   = 4'hF;
                o_wb_cyc   = i_ibus_cyc && !to_hit;
                o_ibus_ack = i_wb_ack || to_hit;
                o_ibus_rdt = i_wb_ack ? i_wb_rdt : '0;
            end
            GNT_D: begin
                o_wb_adr   = i_dbus_adr;
                o_wb_dat   = i_dbus_dat;
                o_wb_sel   = i_dbus_sel;
                o_wb_we    = i_dbus_we;
                o_wb_cyc   = i_dbus_cyc && !to_hit;
                o_dbus_ack = i_wb_ack || to_hit;
                o_dbus_rdt = i_wb_ack ? i_wb_rdt : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter: vector table plus reset, fairness and watchdog sequences.
module tb_serv_bus_arbiter;

    localparam logic [31:0] IADR = 32'h0000_0100;
    localparam logic [31:0] DADR = 32'h0000_2000;
    localparam logic [31:0] DDAT = 32'hA5A5_A5A5;
    localparam logic [3:0]  DSEL = 4'h3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus_adr, dbus_adr, dbus_dat, wb_rdt;
    logic [3:0]  dbus_sel;
    logic        ibus_cyc, dbus_cyc, dbus_we, wb_ack;
    logic [31:0] ibus_rdt, dbus_rdt, wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        ibus_ack, dbus_ack, wb_we, wb_cyc, timeout;

    logic        f_icyc, f_dcyc, f_wb_ack;
    logic [31:0] f_ibus_rdt, f_dbus_rdt, f_wb_adr, f_wb_dat;
    logic [3:0]  f_wb_sel;
    logic        f_iack, f_dack, f_wb_we, f_wb_cyc, f_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serv_bus_arbiter #(.FAIR(0), .TIMEOUT(4)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(timeout)
    );

    serv_bus_arbiter #(.FAIR(1), .TIMEOUT(255)) dut_fair (
        .clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(f_icyc), .o_ibus_rdt(f_ibus_rdt), .o_ibus_ack(f_iack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(f_dcyc), .o_dbus_rdt(f_dbus_rdt), .o_dbus_ack(f_dack),
        .o_wb_adr(f_wb_adr), .o_wb_dat(f_wb_dat), .o_wb_sel(f_wb_sel), .o_wb_we(f_wb_we), .o_wb_cyc(f_wb_cyc),
        .i_wb_rdt(wb_rdt), .i_wb_ack(f_wb_ack), .o_timeout(f_timeout)
    );

    typedef struct {
        logic        icyc, dcyc, we, ack;
        logic [31:0] rdt;
        logic        e_cyc;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_we, e_iack, e_dack;
        logic [31:0] e_irdt, e_drdt;
    } vec_t;

    // gnt: 0 = none, 1 = ibus routed to the port, 2 = dbus routed to the port
    function automatic vec_t mk(input logic icyc, input logic dcyc, input logic we, input logic ack,
                                input logic [31:0] rdt, input logic cyc, input int gnt,
                                input logic iack, input logic dack);
        vec_t v;
        v.icyc = icyc; v.dcyc = dcyc; v.we = we; v.ack = ack; v.rdt = rdt;
        v.e_cyc  = cyc;
        v.e_adr  = (gnt == 1) ? IADR : (gnt == 2) ? DADR : 32'h0;
        v.e_dat  = (gnt == 2) ? DDAT : 32'h0;
        v.e_sel  = (gnt == 1) ? 4'hF : (gnt == 2) ? DSEL : 4'h0;
        v.e_we   = (gnt == 2) ? we : 1'b0;
        v.e_iack = iack;
        v.e_dack = dack;
        v.e_irdt = iack ? rdt : 32'h0;
        v.e_drdt = dack ? rdt : 32'h0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[21];

    initial begin
        logic found;
        logic exp_d;

        vecs[0]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 32'h0,        1, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 32'h13,       1, 1, 1, 0);
        vecs[4]  = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 1, 1, 32'hDEAD_BEEF, 1, 2, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 1, 32'h55,       0, 0, 0, 0);
        vecs[8]  = mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 1, 32'h77,       1, 2, 0, 1);
        vecs[10] = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 1, 32'h99,       1, 1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 32'h0,        1, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 1, 32'h44,       0, 0, 0, 0);
        vecs[17] = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 0);
        vecs[18] = mk(1, 1, 1, 0, 32'h0,        1, 2, 0, 0);
        vecs[19] = mk(0, 1, 1, 1, 32'h11,       1, 2, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0);

        rst_n = 1'b0;
        ibus_adr = IADR; dbus_adr = DADR; dbus_dat = DDAT; dbus_sel = DSEL;
        ibus_cyc = 0; dbus_cyc = 0; dbus_we = 0; wb_ack = 0; wb_rdt = '0;
        f_icyc = 0; f_dcyc = 0; f_wb_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_main", {wb_adr | wb_dat, 28'h0, wb_sel | {wb_we, wb_cyc, ibus_ack, dbus_ack}}, 32'h0);
        check("reset_fair", {31'h0, f_wb_cyc | f_iack | f_dack}, 32'h0);
        check("reset_timeout", {31'h0, timeout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-by-cycle vector table, driven after negedge and checked 1 ns later.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            ibus_cyc = vecs[i].icyc; dbus_cyc = vecs[i].dcyc; dbus_we = vecs[i].we;
            wb_ack = vecs[i].ack; wb_rdt = vecs[i].rdt;
            #1;
            n_checks++;
            if (wb_cyc !== vecs[i].e_cyc || wb_adr !== vecs[i].e_adr || wb_dat !== vecs[i].e_dat ||
                wb_sel !== vecs[i].e_sel || wb_we !== vecs[i].e_we || ibus_ack !== vecs[i].e_iack ||
                dbus_ack !== vecs[i].e_dack || ibus_rdt !== vecs[i].e_irdt || dbus_rdt !== vecs[i].e_drdt) begin
                n_fail++;
                $display("FAIL vec%0d: got cyc=%b adr=%h dat=%h sel=%h we=%b iack=%b dack=%b irdt=%h drdt=%h, expected cyc=%b adr=%h dat=%h sel=%h we=%b iack=%b dack=%b irdt=%h drdt=%h",
                         i, wb_cyc, wb_adr, wb_dat, wb_sel, wb_we, ibus_ack, dbus_ack, ibus_rdt, dbus_rdt,
                         vecs[i].e_cyc, vecs[i].e_adr, vecs[i].e_dat, vecs[i].e_sel, vecs[i].e_we,
                         vecs[i].e_iack, vecs[i].e_dack, vecs[i].e_irdt, vecs[i].e_drdt);
            end
        end

        // FAIR=1: both requesters held high, grants must alternate D, I, D, I.
        @(negedge clk);
        f_icyc = 1; f_dcyc = 1; wb_rdt = 32'h0000_ABCD;
        for (int r = 0; r < 4; r++) begin
            exp_d = (r % 2 == 0);
            found = 1'b0;
            for (int k = 0; k < 6 && !found; k++) begin
                @(negedge clk);
                #1;
                if (f_wb_cyc) found = 1'b1;
            end
            check($sformatf("fair_grant%0d_found", r), {31'h0, found}, 32'h1);
            check($sformatf("fair_grant%0d_adr", r), f_wb_adr, exp_d ? DADR : IADR);
            f_wb_ack = 1;
            #1;
            check($sformatf("fair_ack%0d", r), {30'h0, f_iack, f_dack}, exp_d ? 32'h1 : 32'h2);
            @(negedge clk);
            f_wb_ack = 0;
        end
        f_icyc = 0; f_dcyc = 0;

        // Asynchronous reset in the middle of a dbus grant.
        @(negedge clk);
        dbus_cyc = 1; dbus_we = 1;
        @(negedge clk);
        #1;
        check("pre_reset_cyc", {31'h0, wb_cyc}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_cyc", {31'h0, wb_cyc}, 32'h0);
        dbus_cyc = 0; dbus_we = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_idle", {wb_adr | wb_dat, 28'h0, wb_sel | {wb_we, wb_cyc, ibus_ack, dbus_ack}}, 32'h0);

`ifdef ARB_TIMEOUT_EN
        // TIMEOUT=4 with a memory that never acks.
        wb_rdt = 32'hFFFF_FFFF;
        dbus_cyc = 1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            #1;
            if (k < 4) begin
                check($sformatf("to_wait%0d", k), {30'h0, wb_cyc, dbus_ack}, 32'h2);
                check($sformatf("to_flag_low%0d", k), {31'h0, timeout}, 32'h0);
            end else begin
                check("to_ack", {29'h0, wb_cyc, dbus_ack, ibus_ack}, 32'h2);
                check("to_rdt", dbus_rdt, 32'h0);
                check("to_flag", {31'h0, timeout}, 32'h1);
            end
        end
        @(negedge clk);
        dbus_cyc = 0;
        #1;
        check("to_idle", {31'h0, wb_cyc}, 32'h0);
        check("to_sticky", {31'h0, timeout}, 32'h1);
        ibus_cyc = 1;
        @(negedge clk);
        #1;
        check("to_ibus_cyc", {31'h0, wb_cyc}, 32'h1);
        wb_ack = 1; wb_rdt = 32'h13;
        #1;
        check("to_ibus_ack", {31'h0, ibus_ack}, 32'h1);
        check("to_ibus_rdt", ibus_rdt, 32'h13);
        @(negedge clk);
        wb_ack = 0; ibus_cyc = 0;
        #1;
        check("to_sticky_end", {31'h0, timeout}, 32'h1);
`else
        // Without the watchdog a grant with no ack never completes and o_timeout stays 0.
        dbus_cyc = 1;
        repeat (10) @(negedge clk);
        #1;
        check("nowd_hold_cyc", {30'h0, wb_cyc, dbus_ack}, 32'h2);
        check("nowd_timeout", {31'h0, timeout}, 32'h0);
        dbus_cyc = 0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
